// File: rtl/gpio_irq_device.sv
// gpio_irq_device
//   GPIO peripheral behind the peripheral bus decoder. Per-pin output enable
//   and output value registers, a synchronised input register, atomic
//   set/clear/toggle of the output register, and per-pin rising/falling edge
//   interrupts collected in a write-1-to-clear status register whose OR
//   drives a single irq line.
//
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   peripheralEnable           bus cycle targets peripheral space
//   peripheralBus_we/_oe       write / read strobes
//   peripheralBus_busy         always 0
//   peripheralBus_address      [15:12] device ID, [11:0] local byte address
//   peripheralBus_byteSelect   byte lane enables for writes
//   peripheralBus_dataRead     read data (all ones when not driving)
//   peripheralBus_dataWrite    write data
//   requestOutput              this device drives dataRead this cycle
//   gpio_input                 asynchronous pad inputs
//   gpio_output, gpio_oe       pad output values / output enables (1 = drive)
//   irq                        OR of the interrupt status bits
//
// Bus handshake: the bus has no wait states. A write is accepted when the
// device is selected and peripheralBus_we is high, and lands on the next clk
// edge. A read is answered combinationally in the same cycle; requestOutput
// is high exactly when the device is selected, peripheralBus_oe is high and
// the local address is mapped.
module gpio_irq_device #(
  parameter logic [3:0]          ID          = 4'h0,
  parameter int                  IO_COUNT    = 16,
  parameter int                  SYNC_STAGES = 2,
  parameter logic [IO_COUNT-1:0] OE_DEFAULT  = '1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                peripheralEnable,
  input  logic                peripheralBus_we,
  input  logic                peripheralBus_oe,
  output logic                peripheralBus_busy,
  input  logic [15:0]         peripheralBus_address,
  input  logic [3:0]          peripheralBus_byteSelect,
  output logic [31:0]         peripheralBus_dataRead,
  input  logic [31:0]         peripheralBus_dataWrite,
  output logic                requestOutput,
  input  logic [IO_COUNT-1:0] gpio_input,
  output logic [IO_COUNT-1:0] gpio_output,
  output logic [IO_COUNT-1:0] gpio_oe,
  output logic                irq
);

  localparam logic [11:0] A_OE      = 12'h000;
  localparam logic [11:0] A_OUT     = 12'h004;
  localparam logic [11:0] A_IN      = 12'h008;
  localparam logic [11:0] A_OUT_SET = 12'h00C;
  localparam logic [11:0] A_OUT_CLR = 12'h010;
  localparam logic [11:0] A_OUT_TGL = 12'h014;
  localparam logic [11:0] A_RISE_EN = 12'h018;
  localparam logic [11:0] A_FALL_EN = 12'h01C;
  localparam logic [11:0] A_STATUS  = 12'h020;

  // Priming covers the time for the synchroniser and the prev register to
  // fill with real pad values after reset.
  localparam logic [2:0] PRIME_DONE = 3'(SYNC_STAGES + 1);

  // Bus decode
  logic        sel;
  logic        wr_en;
  logic        rd_en;
  logic [11:0] loc;
  logic [31:0] lane_mask32;
  logic [31:0] wbits32;
  logic [IO_COUNT-1:0] lane_mask;
  logic [IO_COUNT-1:0] wbits;

  assign sel   = peripheralEnable && (peripheralBus_address[15:12] == ID);
  assign wr_en = sel && peripheralBus_we;
  assign rd_en = sel && peripheralBus_oe;
  assign loc   = peripheralBus_address[11:0];

  assign lane_mask32 = {{8{peripheralBus_byteSelect[3]}}, {8{peripheralBus_byteSelect[2]}},
                        {8{peripheralBus_byteSelect[1]}}, {8{peripheralBus_byteSelect[0]}}};
  assign wbits32     = peripheralBus_dataWrite & lane_mask32;
  assign lane_mask   = lane_mask32[IO_COUNT-1:0];
  assign wbits       = wbits32[IO_COUNT-1:0];

  // Bits above IO_COUNT carry no storage; fold them away explicitly.
  logic unused_bits;
  assign unused_bits = ^{lane_mask32, wbits32};

  // State
  logic [IO_COUNT-1:0] oe_q, oe_d;
  logic [IO_COUNT-1:0] out_q, out_d;
  logic [IO_COUNT-1:0] rise_en_q, rise_en_d;
  logic [IO_COUNT-1:0] fall_en_q, fall_en_d;
  logic [IO_COUNT-1:0] status_q, status_d;
  logic [IO_COUNT-1:0] sync_q [SYNC_STAGES];
  logic [IO_COUNT-1:0] prev_q;
  logic [2:0]          prime_cnt_q, prime_cnt_d;

  // Edge detection
  logic [IO_COUNT-1:0] sync_val;
  logic [IO_COUNT-1:0] rise;
  logic [IO_COUNT-1:0] fall;
  logic [IO_COUNT-1:0] set_evt;
  logic [IO_COUNT-1:0] w1c;
  logic                primed;

  assign sync_val = sync_q[SYNC_STAGES-1];
  assign rise     = sync_val & ~prev_q;
  assign fall     = ~sync_val & prev_q;
  assign primed   = (prime_cnt_q == PRIME_DONE);
  assign set_evt  = primed ? ((rise & rise_en_q) | (fall & fall_en_q)) : '0;

  always_comb begin
    oe_d        = oe_q;
    out_d       = out_q;
    rise_en_d   = rise_en_q;
    fall_en_d   = fall_en_q;
    w1c         = '0;
    prime_cnt_d = primed ? prime_cnt_q : prime_cnt_q + 3'd1;
    if (wr_en) begin
      unique case (loc)
        A_OE:      oe_d      = (oe_q & ~lane_mask) | wbits;
        A_OUT:     out_d     = (out_q & ~lane_mask) | wbits;
        A_OUT_SET: out_d     = out_q | wbits;
        A_OUT_CLR: out_d     = out_q & ~wbits;
        A_OUT_TGL: out_d     = out_q ^ wbits;
        A_RISE_EN: rise_en_d = (rise_en_q & ~lane_mask) | wbits;
        A_FALL_EN: fall_en_d = (fall_en_q & ~lane_mask) | wbits;
        A_STATUS:  w1c       = wbits;
        default:   ;
      endcase
    end
    // A new event is ORed in after the clear, so it survives a same-cycle W1C.
    status_d = (status_q & ~w1c) | set_evt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oe_q        <= OE_DEFAULT;
      out_q       <= '0;
      rise_en_q   <= '0;
      fall_en_q   <= '0;
      status_q    <= '0;
      prev_q      <= '0;
      prime_cnt_q <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      oe_q        <= oe_d;
      out_q       <= out_d;
      rise_en_q   <= rise_en_d;
      fall_en_q   <= fall_en_d;
      status_q    <= status_d;
      prev_q      <= sync_val;
      prime_cnt_q <= prime_cnt_d;
      sync_q[0]   <= gpio_input;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Read mux
  logic [IO_COUNT-1:0] rd_val;
  logic                rd_mapped;

  always_comb begin
    rd_val    = '0;
    rd_mapped = 1'b1;
    unique case (loc)
      A_OE:      rd_val = oe_q;
      A_OUT:     rd_val = out_q;
      A_IN:      rd_val = sync_val;
      A_OUT_SET,
      A_OUT_CLR,
      A_OUT_TGL: rd_val = '0;
      A_RISE_EN: rd_val = rise_en_q;
      A_FALL_EN: rd_val = fall_en_q;
      A_STATUS:  rd_val = status_q;
      default:   rd_mapped = 1'b0;
    endcase
  end

  assign requestOutput          = rd_en && rd_mapped;
  assign peripheralBus_dataRead = requestOutput ? 32'(rd_val) : '1;
  assign peripheralBus_busy     = 1'b0;

  assign gpio_output = out_q;
  assign gpio_oe     = oe_q;
  assign irq         = |status_q;

endmodule

// File: tb/tb_gpio_irq_device.sv
// tb_gpio_irq_device
//   Directed scenarios followed by random bus/pin traffic. A reference model
//   keeps the register contents and a history of sampled pad values; read
//   responses are queued as they are issued and popped by a negedge monitor.
module tb_gpio_irq_device;

  localparam int          IO   = 16;
  localparam int          S    = 2;
  localparam logic [31:0] MASK = 32'h0000_FFFF;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // DUT signals
  logic          pe = 1'b0;
  logic          we = 1'b0;
  logic          oe_s = 1'b0;
  logic          busy;
  logic [15:0]   addr = '0;
  logic [3:0]    bs = '0;
  logic [31:0]   rdata;
  logic [31:0]   wdata = '0;
  logic          req_out;
  logic [IO-1:0] gpio_in = '0;
  logic [IO-1:0] gpio_out;
  logic [IO-1:0] gpio_oe;
  logic          irq;

  gpio_irq_device #(.ID(4'h0), .IO_COUNT(IO), .SYNC_STAGES(S), .OE_DEFAULT(16'hFFFF)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .peripheralEnable        (pe),
    .peripheralBus_we        (we),
    .peripheralBus_oe        (oe_s),
    .peripheralBus_busy      (busy),
    .peripheralBus_address   (addr),
    .peripheralBus_byteSelect(bs),
    .peripheralBus_dataRead  (rdata),
    .peripheralBus_dataWrite (wdata),
    .requestOutput           (req_out),
    .gpio_input              (gpio_in),
    .gpio_output             (gpio_out),
    .gpio_oe                 (gpio_oe),
    .irq                     (irq)
  );

  // Scoreboard state
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  bit          exp_req = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model
  logic [31:0] m_oe, m_out, m_rise, m_fall, m_status;
  logic [31:0] hist[$];   // hist[0] = newest pad sample
  int          edge_idx;  // clock edges since reset release

  task automatic model_reset();
    m_oe = MASK; m_out = 0; m_rise = 0; m_fall = 0; m_status = 0;
    edge_idx = 0;
    hist = {};
    for (int i = 0; i <= S; i++) hist.push_back(32'h0);
  endtask

  task automatic model_edge();
    logic [31:0] sync_pre, prev_pre, set_evt, lane, wb, w1c;
    sync_pre = hist[S-1];
    prev_pre = hist[S];
    edge_idx++;
    set_evt = 0;
    if (edge_idx >= S + 2)
      set_evt = ((sync_pre & ~prev_pre & m_rise) | (~sync_pre & prev_pre & m_fall)) & MASK;
    w1c = 0;
    if (pe && we && addr[15:12] == 4'h0) begin
      lane = 0;
      for (int b = 0; b < 4; b++) if (bs[b]) lane |= 32'hFF << (8 * b);
      lane &= MASK;
      wb = wdata & lane;
      case (addr[11:0])
        12'h000: m_oe   = (m_oe & ~lane) | wb;
        12'h004: m_out  = (m_out & ~lane) | wb;
        12'h00C: m_out  = m_out | wb;
        12'h010: m_out  = m_out & ~wb;
        12'h014: m_out  = m_out ^ wb;
        12'h018: m_rise = (m_rise & ~lane) | wb;
        12'h01C: m_fall = (m_fall & ~lane) | wb;
        12'h020: w1c    = wb;
        default: ;
      endcase
    end
    m_status = (m_status & ~w1c) | set_evt;
    hist.push_front({16'h0, gpio_in});
    void'(hist.pop_back());
  endtask

  task automatic model_read(input logic [15:0] a, output bit req, output logic [31:0] val);
    req = (a[15:12] == 4'h0);
    val = 32'hFFFF_FFFF;
    case (a[11:0])
      12'h000: val = m_oe;
      12'h004: val = m_out;
      12'h008: val = hist[S-1];
      12'h00C, 12'h010, 12'h014: val = 0;
      12'h018: val = m_rise;
      12'h01C: val = m_fall;
      12'h020: val = m_status;
      default: req = 1'b0;
    endcase
    if (!req) val = 32'hFFFF_FFFF;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) model_reset();
    else     model_edge();
  end

  // Monitor: compares pad outputs, irq and read responses every cycle
  initial forever begin
    @(negedge clk);
    check("irq", {31'h0, irq}, {31'h0, |m_status});
    check("gpio_output", {16'h0, gpio_out}, m_out);
    check("gpio_oe", {16'h0, gpio_oe}, m_oe);
    check("busy", {31'h0, busy}, 32'h0);
    check("request_output", {31'h0, req_out}, {31'h0, exp_req});
    if (req_out) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL read_data: got unexpected response %h expected none", rdata);
      end else begin
        check("read_data", rdata, exp_q.pop_front());
      end
    end else begin
      check("idle_read_data", rdata, 32'hFFFF_FFFF);
    end
  end

  // Driver tasks
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] lanes);
    pe = 1'b1; we = 1'b1; addr = a; wdata = d; bs = lanes;
    tick();
    pe = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, input bit chk, input logic [31:0] want,
                          input string name);
    bit          req;
    logic [31:0] v;
    model_read(a, req, v);
    pe = 1'b1; oe_s = 1'b1; addr = a;
    exp_req = req;
    if (req) exp_q.push_back(v);
    if (chk) begin
      @(negedge clk);
      check(name, rdata, want);
    end
    tick();
    pe = 1'b0; oe_s = 1'b0; exp_req = 1'b0;
  endtask

  // Watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    gpio_in = 16'hFFFF;
    #1 rst = 1'b1;
    tick(3);
    rst = 1'b0;

    // Pins high through reset; rising enables written during priming
    bus_write(16'h0018, 32'hFFFF_FFFF, 4'hF);
    tick(5);
    bus_read(16'h0020, 1, 32'h0, "t1_status_no_false_edge");
    bus_read(16'h0008, 1, 32'h0000_FFFF, "t1_in_all_high");
    bus_read(16'h0000, 1, 32'h0000_FFFF, "t1_oe_reset");
    bus_read(16'h0004, 1, 32'h0, "t1_out_reset");
    bus_read(16'h001C, 1, 32'h0, "t1_fall_en_reset");
    check("t1_irq_low", {31'h0, irq}, 32'h0);

    // Atomic output operations
    bus_write(16'h0004, 32'h0000_00F0, 4'hF);
    bus_write(16'h000C, 32'h0000_0003, 4'hF);
    bus_write(16'h0010, 32'h0000_0010, 4'hF);
    bus_write(16'h0014, 32'h0000_8001, 4'hF);
    bus_read(16'h0004, 1, 32'h0000_80E2, "t2_out");
    bus_read(16'h000C, 1, 32'h0, "t2_set_reads_zero");
    check("t2_gpio_output", {16'h0, gpio_out}, 32'h0000_80E2);

    // Rising edge latency and W1C
    gpio_in = 16'h0000;
    tick(4);
    bus_write(16'h0020, 32'hFFFF_FFFF, 4'hF);
    bus_write(16'h0018, 32'h0000_0001, 4'hF);
    bus_write(16'h001C, 32'h0, 4'hF);
    gpio_in = 16'h0001;
    tick();
    bus_read(16'h0008, 1, 32'h0, "t3_in_before");
    check("t3_irq_before", {31'h0, irq}, 32'h0);
    bus_read(16'h0008, 1, 32'h1, "t3_in_after");
    check("t3_irq_set", {31'h0, irq}, 32'h1);
    bus_read(16'h0020, 1, 32'h1, "t3_status");
    bus_write(16'h0020, 32'h1, 4'hF);
    check("t3_irq_cleared", {31'h0, irq}, 32'h0);

    // Set event and W1C on the same bit in the same cycle
    bus_write(16'h001C, 32'h0000_0004, 4'hF);
    gpio_in = 16'h0005;
    tick(4);
    bus_write(16'h0020, 32'hFFFF_FFFF, 4'hF);
    gpio_in = 16'h0001;
    tick(2);
    bus_write(16'h0020, 32'h0000_0004, 4'hF);
    bus_read(16'h0020, 1, 32'h4, "t4_set_wins");

    // Random traffic
    for (int it = 0; it < 400; it++) begin
      int          op;
      int          idx;
      logic [3:0]  id;
      op = $urandom_range(0, 9);
      id = ($urandom_range(0, 9) == 0) ? 4'h3 : 4'h0;
      if (op <= 2) begin
        if ($urandom_range(0, 3) == 0) gpio_in = 16'($urandom);
        else gpio_in = gpio_in ^ (16'h1 << $urandom_range(0, 15));
        tick();
      end else if (op <= 5) begin
        idx = $urandom_range(0, 8);
        bus_write({id, 12'(idx * 4)}, $urandom, 4'($urandom_range(0, 15)));
      end else if (op <= 8) begin
        idx = $urandom_range(0, 10);
        if (idx == 10) bus_read({id, 12'h100}, 0, 32'h0, "rnd");
        else bus_read({id, 12'(idx * 4)}, 0, 32'h0, "rnd");
      end else begin
        tick();
      end
    end

    // Byte-lane masking and unmapped read
    bus_write(16'h0000, 32'h0, 4'hF);
    bus_write(16'h0000, 32'hFFFF_FFFF, 4'b0001);
    bus_read(16'h0000, 1, 32'h0000_00FF, "t5_oe_lane0");
    check("t5_gpio_oe", {16'h0, gpio_oe}, 32'h0000_00FF);
    bus_read(16'h0024, 1, 32'hFFFF_FFFF, "t5_unmapped_data");
    bus_read(16'h1000, 1, 32'hFFFF_FFFF, "t5_other_id_data");

    // Reset in the middle of operation
    gpio_in = 16'h0000;
    tick(4);
    bus_write(16'h0020, 32'hFFFF_FFFF, 4'hF);
    bus_write(16'h0018, 32'h0000_0005, 4'hF);
    bus_write(16'h001C, 32'h0, 4'hF);
    bus_write(16'h0004, 32'h0000_1234, 4'h3);
    gpio_in = 16'h0005;
    tick(4);
    bus_read(16'h0020, 1, 32'h5, "t6_status_before");
    check("t6_irq_before", {31'h0, irq}, 32'h1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_irq_async", {31'h0, irq}, 32'h0);
    check("t6_out_async", {16'h0, gpio_out}, 32'h0);
    check("t6_oe_async", {16'h0, gpio_oe}, 32'h0000_FFFF);
    tick(2);
    rst = 1'b0;
    bus_write(16'h0018, 32'h0000_0005, 4'hF);
    tick(5);
    bus_read(16'h0020, 1, 32'h0, "t6_status_after");
    bus_read(16'h0004, 1, 32'h0, "t6_out_after");
    bus_read(16'h0000, 1, 32'h0000_FFFF, "t6_oe_after");
    bus_read(16'h0008, 1, 32'h0000_0005, "t6_in_after");

    tick(2);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
